// File: rtl/tff_ctrl_pkg.sv
// rtl/tff_ctrl_pkg.sv - shared state encoding and default width for the T flip-flop counter
package tff_ctrl_pkg;

    localparam int DEFAULT_WIDTH = 3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    // RUN and PAUSE are the two states in which a count is in progress
    function automatic logic is_busy(input state_t s);
        return (s == ST_RUN) || (s == ST_PAUSE);
    endfunction

endpackage

// File: rtl/tff_cell.sv
// rtl/tff_cell.sv - single T flip-flop stage with synchronous parallel load
module tff_cell (
    input  logic CLK,
    input  logic RST_N,
    input  logic T,
    input  logic LD,
    input  logic D,
    output logic Q
);

    // Load takes precedence over toggle; the controller never asserts both together
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            Q <= 1'b0;
        end else if (LD) begin
            Q <= D;
        end else if (T) begin
            Q <= ~Q;
        end
    end

endmodule

// File: rtl/tff_count_ctrl.sv
// rtl/tff_count_ctrl.sv - up/down T flip-flop counter with run/pause/one-shot control FSM
module tff_count_ctrl
    import tff_ctrl_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             START,
    input  logic             STOP,
    input  logic             HOLD,
    input  logic             DIR,
    input  logic             ONE_SHOT,
    input  logic             LOAD_EN,
    input  logic [WIDTH-1:0] LOAD_VAL,
    input  logic [WIDTH-1:0] TERM,
    output logic [WIDTH-1:0] Q,
    output logic [WIDTH-1:0] T,
    output logic             BUSY,
    output logic             DONE,
    output logic             WRAP
);

    state_t           state;
    state_t           state_nxt;
    logic             count_en;
    logic             load;
    logic             at_term;
    logic             wrap_hit;
    logic [WIDTH-1:0] run_t;

    assign at_term = ONE_SHOT && (Q == TERM);

    // State register
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state, count enable and load request; STOP > HOLD > terminal > START
    always_comb begin
        state_nxt = state;
        count_en  = 1'b0;
        load      = 1'b0;
        case (state)
            ST_IDLE: begin
                if (!STOP) begin
                    load = LOAD_EN;
                    if (START && !HOLD) begin
                        state_nxt = ST_RUN;
                    end
                end
            end
            ST_RUN: begin
                if (STOP) begin
                    state_nxt = ST_IDLE;
                end else if (HOLD) begin
                    state_nxt = ST_PAUSE;
                end else if (at_term) begin
                    state_nxt = ST_DONE;
                end else begin
                    count_en = 1'b1;
                end
            end
            ST_PAUSE: begin
                if (STOP) begin
                    state_nxt = ST_IDLE;
                end else if (!HOLD) begin
                    state_nxt = ST_RUN;
                end
            end
            ST_DONE: begin
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // Stage i flips when every lower stage sits at the carry value (up) or borrow value (down)
    always_comb begin
        logic carry;
        carry = 1'b1;
        run_t = '0;
        for (int i = 0; i < WIDTH; i++) begin
            run_t[i] = carry;
            carry    = carry & (DIR ? ~Q[i] : Q[i]);
        end
    end

    assign T        = count_en ? run_t : '0;
    assign wrap_hit = count_en && (DIR ? (Q == '0) : (&Q));

    // Wrap pulse registered alongside the count edge that crosses the boundary
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            WRAP <= 1'b0;
        end else begin
            WRAP <= wrap_hit;
        end
    end

    assign BUSY = is_busy(state);
    assign DONE = (state == ST_DONE);

    for (genvar i = 0; i < WIDTH; i++) begin : g_stage
        tff_cell u_cell (
            .CLK   (CLK),
            .RST_N (RST_N),
            .T     (T[i]),
            .LD    (load),
            .D     (LOAD_VAL[i]),
            .Q     (Q[i])
        );
    end

endmodule

// File: tb/tb_tff_count_ctrl.sv
// tb/tb_tff_count_ctrl.sv - scoreboard bench for tff_count_ctrl with reference model
module tb_tff_count_ctrl;

    localparam int W       = 3;
    localparam int MOD     = 1 << W;
    localparam int M_IDLE  = 0;
    localparam int M_RUN   = 1;
    localparam int M_PAUSE = 2;
    localparam int M_DONE  = 3;

    logic         CLK      = 1'b0;
    logic         RST_N    = 1'b0;
    logic         START    = 1'b0;
    logic         STOP     = 1'b0;
    logic         HOLD     = 1'b0;
    logic         DIR      = 1'b0;
    logic         ONE_SHOT = 1'b0;
    logic         LOAD_EN  = 1'b0;
    logic [W-1:0] LOAD_VAL = '0;
    logic [W-1:0] TERM     = '0;
    logic [W-1:0] Q;
    logic [W-1:0] T;
    logic         BUSY;
    logic         DONE;
    logic         WRAP;

    typedef struct {
        int q;
        int t;
        bit busy;
        bit done;
        bit wrap;
    } exp_t;

    exp_t sb[$];
    int   tests  = 0;
    int   fails  = 0;
    int   m_mode = M_IDLE;
    int   m_q    = 0;
    bit   m_wrap = 1'b0;

    tff_count_ctrl #(.WIDTH(W)) dut (
        .CLK      (CLK),
        .RST_N    (RST_N),
        .START    (START),
        .STOP     (STOP),
        .HOLD     (HOLD),
        .DIR      (DIR),
        .ONE_SHOT (ONE_SHOT),
        .LOAD_EN  (LOAD_EN),
        .LOAD_VAL (LOAD_VAL),
        .TERM     (TERM),
        .Q        (Q),
        .T        (T),
        .BUSY     (BUSY),
        .DONE     (DONE),
        .WRAP     (WRAP)
    );

    always #5 CLK = ~CLK;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s at %0t: actual=%0d required=%0d", name, $time, act, exp);
        end
    endtask

    function automatic int step_val(input int q, input bit down);
        return down ? (q + MOD - 1) % MOD : (q + 1) % MOD;
    endfunction

    // Reference behaviour for one rising edge using the inputs currently applied
    task automatic model_step();
        int nq;
        if (!RST_N) begin
            m_mode = M_IDLE;
            m_q    = 0;
            m_wrap = 1'b0;
        end else begin
            m_wrap = 1'b0;
            case (m_mode)
                M_IDLE: begin
                    if (!STOP) begin
                        if (LOAD_EN) m_q = int'(LOAD_VAL);
                        if (START && !HOLD) m_mode = M_RUN;
                    end
                end
                M_RUN: begin
                    if (STOP) m_mode = M_IDLE;
                    else if (HOLD) m_mode = M_PAUSE;
                    else if (ONE_SHOT && m_q == int'(TERM)) m_mode = M_DONE;
                    else begin
                        nq     = step_val(m_q, DIR);
                        m_wrap = DIR ? (nq == MOD - 1) : (nq == 0);
                        m_q    = nq;
                    end
                end
                M_PAUSE: begin
                    if (STOP) m_mode = M_IDLE;
                    else if (!HOLD) m_mode = M_RUN;
                end
                default: m_mode = M_IDLE;
            endcase
        end
    endtask

    task automatic push_expect();
        exp_t e;
        bit   counting;
        counting = RST_N && (m_mode == M_RUN) && !STOP && !HOLD
                   && !(ONE_SHOT && m_q == int'(TERM));
        e.q    = m_q;
        e.busy = (m_mode == M_RUN) || (m_mode == M_PAUSE);
        e.done = (m_mode == M_DONE);
        e.wrap = m_wrap;
        e.t    = counting ? (m_q ^ step_val(m_q, DIR)) : 0;
        sb.push_back(e);
    endtask

    task automatic drive(input bit st, input bit sp, input bit hd, input bit dr,
                         input bit os, input bit ld, input int lv, input int tm);
        @(posedge CLK);
        model_step();
        #1;
        START    = st;
        STOP     = sp;
        HOLD     = hd;
        DIR      = dr;
        ONE_SHOT = os;
        LOAD_EN  = ld;
        LOAD_VAL = lv[W-1:0];
        TERM     = tm[W-1:0];
        push_expect();
    endtask

    task automatic idle_inputs();
        START   = 1'b0;
        STOP    = 1'b0;
        HOLD    = 1'b0;
        LOAD_EN = 1'b0;
    endtask

    task automatic async_reset();
        @(negedge CLK);
        #1;
        RST_N = 1'b0;
        #1;
        check("async_rst_q", int'(Q), 0);
        check("async_rst_busy", int'(BUSY), 0);
        check("async_rst_t", int'(T), 0);
        check("async_rst_done", int'(DONE), 0);
        check("async_rst_wrap", int'(WRAP), 0);
        m_mode = M_IDLE;
        m_q    = 0;
        m_wrap = 1'b0;
        idle_inputs();
    endtask

    task automatic release_reset();
        @(posedge CLK);
        model_step();
        #1;
        RST_N = 1'b1;
        push_expect();
    endtask

    // Monitor: compare each cycle's outputs against the oldest expectation
    initial begin
        forever begin
            @(negedge CLK);
            if (sb.size() > 0) begin
                exp_t e;
                e = sb.pop_front();
                check("q", int'(Q), e.q);
                check("t", int'(T), e.t);
                check("busy", int'(BUSY), int'(e.busy));
                check("done", int'(DONE), int'(e.done));
                check("wrap", int'(WRAP), int'(e.wrap));
            end
        end
    end

    initial begin
        bit st, sp, hd, dr, os, ld;
        int lv, tm;

        #1;
        check("reset_q", int'(Q), 0);
        check("reset_t", int'(T), 0);
        check("reset_busy", int'(BUSY), 0);
        check("reset_done", int'(DONE), 0);
        check("reset_wrap", int'(WRAP), 0);
        release_reset();

        // Up one-shot 0 -> 5, then DONE pulse and back to IDLE
        drive(1, 0, 0, 0, 1, 0, 0, 5);
        repeat (8) drive(0, 0, 0, 0, 1, 0, 0, 5);

        // Up free-run from preload 6 across the wrap
        drive(0, 0, 0, 0, 0, 1, 6, 0);
        drive(1, 0, 0, 0, 0, 0, 0, 0);
        repeat (4) drive(0, 0, 0, 0, 0, 0, 0, 0);
        drive(0, 1, 0, 0, 0, 0, 0, 0);

        // Down with simultaneous preload 2 and start
        drive(1, 0, 0, 1, 0, 1, 2, 0);
        repeat (5) drive(0, 0, 0, 1, 0, 0, 0, 0);
        drive(0, 1, 0, 1, 0, 0, 0, 0);

        // Hold for three cycles at Q=3, release, one count, then STOP+HOLD at Q=4
        drive(1, 0, 0, 0, 0, 1, 1, 0);
        repeat (2) drive(0, 0, 0, 0, 0, 0, 0, 0);
        repeat (3) drive(0, 0, 1, 0, 0, 0, 0, 0);
        repeat (2) drive(0, 0, 0, 0, 0, 0, 0, 0);
        drive(0, 1, 1, 0, 0, 0, 0, 0);
        repeat (2) drive(0, 0, 0, 0, 0, 0, 0, 0);

        // Restart from 4, reach 5, reset asynchronously mid-cycle, restart from 0
        drive(1, 0, 0, 0, 0, 0, 0, 0);
        repeat (2) drive(0, 0, 0, 0, 0, 0, 0, 0);
        async_reset();
        release_reset();
        drive(1, 0, 0, 0, 0, 0, 0, 0);
        repeat (4) drive(0, 0, 0, 0, 0, 0, 0, 0);

        // Randomized traffic
        dr = 1'b0;
        tm = 3;
        for (int n = 0; n < 400; n++) begin
            st = ($urandom_range(3) == 0);
            sp = ($urandom_range(15) == 0);
            hd = ($urandom_range(7) == 0);
            if ($urandom_range(7) == 0) dr = ~dr;
            os = ($urandom_range(1) == 1);
            ld = ($urandom_range(5) == 0);
            lv = int'($urandom_range(MOD - 1));
            if ($urandom_range(15) == 0) tm = int'($urandom_range(MOD - 1));
            if ($urandom_range(99) == 0) begin
                async_reset();
                release_reset();
            end else begin
                drive(st, sp, hd, dr, os, ld, lv, tm);
            end
        end

        repeat (2) drive(0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge CLK);
        #1;
        check("sb_drain", sb.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
